reg_bank_wb: RTL and testbench
==============================

# reg_bank_wb

Sixteen-entry, 32-bit register bank that terminates the write-back interface (`reg_wr`, `dir_wb`, write data) and serves the decode stage. It provides two combinational read ports with write-back bypass and a per-register in-flight scoreboard. Decode registers destination writes at issue, and write-back retires them. The block raises `stall` whenever a source operand or destination slot is not yet safe to use.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 4, register address width
- `NUM_REGS`, 16, number of registers (2**ADDR_W)
- `MAX_INFLIGHT`, 3, maximum outstanding writes tracked per register

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `reg_wr_in`  in  1  write-back write enable
- `dir_wb_in`  in  ADDR_W  write-back destination register
- `data_wb_in`  in  DATA_W  write-back data
- `rd_a_addr`, `rd_b_addr`  in  ADDR_W  read port addresses
- `rd_a_data`, `rd_b_data`  out  DATA_W  read port data (combinational)
- `src_a_used`, `src_b_used`  in  1  issuing instruction reads port A / port B
- `issue_valid`  in  1  decode presents an instruction this cycle
- `issue_wr`  in  1  the instruction writes a register
- `issue_dst`  in  ADDR_W  destination of the issuing instruction
- `stall`  out  1  issue must not proceed this cycle (combinational)
- `pending`  out  NUM_REGS  bit r set when cnt[r] != 0 (registered)
- `sb_err`  out  1  sticky retire-underflow flag

## Operation
- Storage: `regs[NUM_REGS]`, DATA_W each. All registers are general purpose; there is no hardwired zero.
- Write: when `reg_wr_in` is high, `regs[dir_wb_in] <= data_wb_in` at the clock edge.
- Read: `rd_x_data = (reg_wr_in && dir_wb_in == rd_x_addr) ? data_wb_in : regs[rd_x_addr]`. The bypass is write-first.
- Scoreboard: `cnt[r]`, width clog2(MAX_INFLIGHT+1), saturating logic.
  - `ret[r]` = `reg_wr_in && dir_wb_in == r && cnt[r] != 0`
  - `eff[r]` = `cnt[r] - ret[r]`
  - `acc` = `issue_valid && !stall`
  - `inc[r]` = `acc && issue_wr && issue_dst == r`
  - `cnt[r] <= cnt[r] - ret[r] + inc[r]`. Simultaneous retire and issue on the same r leaves the count unchanged.
- Stall is asserted when any of the following holds:
  - `issue_valid && src_a_used && eff[rd_a_addr] != 0`
  - `issue_valid && src_b_used && eff[rd_b_addr] != 0`
  - `issue_valid && issue_wr && cnt[issue_dst] == MAX_INFLIGHT`
- `stall` is 0 whenever `issue_valid` is 0.
- Underflow: if `reg_wr_in` is high and `cnt[dir_wb_in] == 0`, the data is still written, the count stays 0, and `sb_err <= 1` until reset.
- An issue presented while `stall` is high is ignored, with no counter change.

## Timing
- Reset (`rst` high at an edge): all `regs` = 0, all `cnt` = 0, `pending` = 0, `sb_err` = 0.
- `rst` overrides a same-cycle write, issue or retire. In-flight counts are discarded; the pipeline is flushed externally.
- Write latency: data is readable the same cycle via bypass and from the array from the next cycle.
- `pending` reflects `cnt` after the edge, one cycle behind `eff`.
- `stall` is purely combinational from the current inputs and `cnt`.
- A retire of the last outstanding write unblocks a dependent issue in the same cycle.

## Structure
- Shared package `jof32_rf_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`, `MAX_INFLIGHT`
  - typedefs `reg_addr_t`, `reg_data_t`, `sb_cnt_t`
- One sub-module, `sb_slot`: one register's counter, taking the `ret`/`inc` inputs and producing `cnt`, `busy` and `underflow`. It is instantiated NUM_REGS times.
- The data array and read muxes stay in the top level.

## Test plan
- Reset then read: assert `rst` for one cycle, then read R0 and R15. Required: both read 0x00000000, `pending` = 0x0000, `sb_err` = 0.
- Bypass:
  - Stimulus: `reg_wr_in`=1, `dir_wb_in`=5, `data_wb_in`=0xDEADBEEF, `rd_a_addr`=5 in the same cycle.
  - Required: `rd_a_data` = 0xDEADBEEF that cycle and still 0xDEADBEEF next cycle with `reg_wr_in`=0.
- RAW stall:
  - Stimulus: issue `issue_wr`, `issue_dst`=3. Next cycle issue with `src_a_used`, `rd_a_addr`=3.
  - Required: `stall`=1 until the cycle `reg_wr_in`/`dir_wb_in`=3 arrives, where `stall`=0 and `rd_a_data` = the write-back data.
- Saturation: three accepted issues to R7 with no retire, then a fourth. Required: `stall`=1, count stays 3, `pending[7]`=1.
- Simultaneous retire and issue on R2 with count 1: required count stays 1 and `pending[2]` stays 1.
- Underflow: write back to R9 with count 0 and value 0x1234. Required: R9 = 0x1234 and `sb_err`=1, held until `rst`.

Source files
------------

// File: rtl/jof32_rf_pkg.sv
// Shared widths and types for the sixteen-entry register bank
// and its write-back scoreboard.
package jof32_rf_pkg;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 4;
    localparam int NUM_REGS     = 16;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

endpackage

// File: rtl/sb_slot.sv
// One register's in-flight write counter: decode increments it at issue,
// write-back decrements it at retire, and a retire against zero is flagged.
module sb_slot
    import jof32_rf_pkg::*;
#(
    parameter int SLOT_MAX = MAX_INFLIGHT,
    parameter int SLOT_W   = CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret,
    input  logic              inc,
    input  logic              wb_hit,
    output logic [SLOT_W-1:0] cnt,
    output logic              busy,
    output logic              underflow
);

    localparam logic [SLOT_W-1:0] CNT_MAX = SLOT_W'(SLOT_MAX);

    // A retire and an issue in the same cycle cancel; increments saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (ret && !inc) begin
            cnt <= cnt - 1'b1;
        end else if (inc && !ret && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign busy      = (cnt != '0);
    assign underflow = wb_hit && (cnt == '0);

endmodule

// File: rtl/reg_bank_wb.sv
// Register bank terminating write-back, with bypassed read ports and a
// per-register scoreboard that stalls decode on unsafe operands.
module reg_bank_wb
    import jof32_rf_pkg::*;
#(
    parameter int DATA_W       = jof32_rf_pkg::DATA_W,
    parameter int ADDR_W       = jof32_rf_pkg::ADDR_W,
    parameter int NUM_REGS     = jof32_rf_pkg::NUM_REGS,
    parameter int MAX_INFLIGHT = jof32_rf_pkg::MAX_INFLIGHT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_wr_in,
    input  logic [ADDR_W-1:0]   dir_wb_in,
    input  logic [DATA_W-1:0]   data_wb_in,
    input  logic [ADDR_W-1:0]   rd_a_addr,
    input  logic [ADDR_W-1:0]   rd_b_addr,
    output logic [DATA_W-1:0]   rd_a_data,
    output logic [DATA_W-1:0]   rd_b_data,
    input  logic                src_a_used,
    input  logic                src_b_used,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic [ADDR_W-1:0]   issue_dst,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic                sb_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CW-1:0]       cnt  [NUM_REGS];
    logic [CW-1:0]       eff  [NUM_REGS];
    logic [NUM_REGS-1:0] wb_hit, ret, inc, busy, underflow;
    logic                acc;

    assign acc = issue_valid && !stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_slot
        assign wb_hit[r] = reg_wr_in && (dir_wb_in == ADDR_W'(r));
        assign ret[r]    = wb_hit[r] && busy[r];
        assign inc[r]    = acc && issue_wr && (issue_dst == ADDR_W'(r));
        assign eff[r]    = cnt[r] - CW'(ret[r]);

        sb_slot #(
            .SLOT_MAX (MAX_INFLIGHT),
            .SLOT_W   (CW)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .ret       (ret[r]),
            .inc       (inc[r]),
            .wb_hit    (wb_hit[r]),
            .cnt       (cnt[r]),
            .busy      (busy[r]),
            .underflow (underflow[r])
        );
    end

    assign pending = busy;

    // Source hazards use the post-retire count so a same-cycle retire unblocks.
    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            if (src_a_used && eff[rd_a_addr] != '0) stall = 1'b1;
            if (src_b_used && eff[rd_b_addr] != '0) stall = 1'b1;
            if (issue_wr && cnt[issue_dst] == CNT_MAX) stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|underflow) begin
            sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_wr_in) begin
            regs[dir_wb_in] <= data_wb_in;
        end
    end

    always_comb begin
        rd_a_data = regs[rd_a_addr];
        rd_b_data = regs[rd_b_addr];
        if (reg_wr_in && dir_wb_in == rd_a_addr) rd_a_data = data_wb_in;
        if (reg_wr_in && dir_wb_in == rd_b_addr) rd_b_data = data_wb_in;
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed and randomized checks of reg_bank_wb against an array-based
// model of the register file and outstanding-write counts.
module tb_reg_bank_wb;
    import jof32_rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_in;
    reg_addr_t   dir_wb_in;
    reg_data_t   data_wb_in;
    reg_addr_t   rd_a_addr, rd_b_addr;
    reg_data_t   rd_a_data, rd_b_data;
    logic        src_a_used, src_b_used;
    logic        issue_valid, issue_wr;
    reg_addr_t   issue_dst;
    logic        stall;
    logic [15:0] pending;
    logic        sb_err;

    int          vectors = 0;
    int          miscompares = 0;

    reg_data_t   model_regs [16];
    int          model_cnt  [16];
    bit          model_err;

    always #5 clk = ~clk;

    reg_bank_wb dut (
        .clk         (clk),
        .rst         (rst),
        .reg_wr_in   (reg_wr_in),
        .dir_wb_in   (dir_wb_in),
        .data_wb_in  (data_wb_in),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .rd_a_data   (rd_a_data),
        .rd_b_data   (rd_b_data),
        .src_a_used  (src_a_used),
        .src_b_used  (src_b_used),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dst   (issue_dst),
        .stall       (stall),
        .pending     (pending),
        .sb_err      (sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic reg_data_t expRead(input reg_addr_t a);
        if (reg_wr_in && dir_wb_in == a) return data_wb_in;
        return model_regs[a];
    endfunction

    // Outstanding writes still owed after any retire arriving this cycle.
    function automatic int owed(input reg_addr_t a);
        int n = model_cnt[a];
        if (reg_wr_in && dir_wb_in == a && n > 0) n--;
        return n;
    endfunction

    function automatic bit expStall();
        if (!issue_valid) return 1'b0;
        if (src_a_used && owed(rd_a_addr) > 0) return 1'b1;
        if (src_b_used && owed(rd_b_addr) > 0) return 1'b1;
        if (issue_wr && model_cnt[issue_dst] >= MAX_INFLIGHT) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] expPending();
        logic [15:0] p = '0;
        for (int i = 0; i < 16; i++) p[i] = (model_cnt[i] != 0);
        return p;
    endfunction

    task automatic checkOutput();
        check("rd_a_data", rd_a_data, expRead(rd_a_addr));
        check("rd_b_data", rd_b_data, expRead(rd_b_addr));
        check("stall", 32'(stall), 32'(expStall()));
        check("pending", 32'(pending), 32'(expPending()));
        check("sb_err", 32'(sb_err), 32'(model_err));
    endtask

    task automatic updateModel(input bit stl);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                model_regs[i] = '0;
                model_cnt[i]  = 0;
            end
            model_err = 1'b0;
        end else begin
            if (reg_wr_in) begin
                model_regs[dir_wb_in] = data_wb_in;
                if (model_cnt[dir_wb_in] == 0) model_err = 1'b1;
                else model_cnt[dir_wb_in]--;
            end
            if (issue_valid && !stl && issue_wr) model_cnt[issue_dst]++;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit wr, input int dir, input logic [31:0] dat,
                                 input int ra, input int rb, input bit sa, input bit sbu,
                                 input bit iv, input bit iw, input int dst);
        rst = r; reg_wr_in = wr; dir_wb_in = reg_addr_t'(dir); data_wb_in = dat;
        rd_a_addr = reg_addr_t'(ra); rd_b_addr = reg_addr_t'(rb);
        src_a_used = sa; src_b_used = sbu;
        issue_valid = iv; issue_wr = iw; issue_dst = reg_addr_t'(dst);
    endtask

    task automatic runCycle(input bit do_check);
        bit stl;
        @(negedge clk);
        stl = expStall();
        if (do_check) checkOutput();
        @(posedge clk);
        updateModel(stl);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_regs[i] = '0;
            model_cnt[i]  = 0;
        end
        model_err = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0);
        runCycle(0);

        applyStimulus(0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0);
        runCycle(1);
        check("reset_r0", rd_a_data, 32'h0);

        applyStimulus(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0);
        runCycle(1);
        applyStimulus(0, 0, 5, 32'h0, 5, 0, 0, 0, 0, 0, 0);
        runCycle(1);
        check("bypass_hold", rd_a_data, 32'hDEADBEEF);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        runCycle(1);
        applyStimulus(0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0);
        runCycle(1);
        check("raw_stall", 32'(stall), 32'h1);
        runCycle(1);
        applyStimulus(0, 1, 3, 32'hCAFE0003, 3, 0, 1, 0, 1, 0, 0);
        #1;
        check("raw_release", 32'(stall), 32'h0);
        check("raw_data", rd_a_data, 32'hCAFE0003);
        runCycle(1);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
            runCycle(1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        #1;
        check("sat_stall", 32'(stall), 32'h1);
        runCycle(1);
        check("sat_pending7", 32'(pending[7]), 32'h1);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        runCycle(1);
        applyStimulus(0, 1, 2, 32'h22222222, 0, 0, 0, 0, 1, 1, 2);
        runCycle(1);
        applyStimulus(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        runCycle(1);
        check("simul_pending2", 32'(pending[2]), 32'h1);

        applyStimulus(0, 1, 9, 32'h00001234, 0, 0, 0, 0, 0, 0, 0);
        runCycle(1);
        applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        runCycle(1);
        check("uflow_data", rd_a_data, 32'h00001234);
        check("uflow_err", 32'(sb_err), 32'h1);

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7), $urandom,
                          $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7));
            runCycle(1);
        end

        applyStimulus(1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0);
        runCycle(0);
        applyStimulus(0, 0, 0, 0, 9, 15, 0, 0, 0, 0, 0);
        runCycle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
